// File: rtl/eros_xbar_varlat_n_to_one.sv
// N-to-1 OBI crossbar: round-robin arbitration with request locking, and an
// in-order ID FIFO that routes each slave response back to its issuing master.

package eros_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module eros_xbar_varlat_n_to_one #(
    parameter int unsigned XBAR_NMASTER    = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter type         obi_req_t       = eros_obi_pkg::obi_req_t,
    parameter type         obi_resp_t      = eros_obi_pkg::obi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  master_req_i  [XBAR_NMASTER],
    output obi_resp_t master_resp_o [XBAR_NMASTER],
    output obi_req_t  slave_req_o,
    input  obi_resp_t slave_resp_i,
    output logic      unexpected_rsp_o
);

    localparam int unsigned IdxWidth = (XBAR_NMASTER > 1) ? $clog2(XBAR_NMASTER) : 1;
    localparam int unsigned PtrWidth = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);

    logic [IdxWidth-1:0] rr_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic                lock_q;
    logic [IdxWidth-1:0] sel;
    logic [IdxWidth-1:0] cand;
    logic                found;
    logic                eligible;
    logic                fifo_full;
    logic                slave_req_valid;
    logic                accept;
    logic                pop;
    logic [IdxWidth-1:0] head_idx;
    logic [IdxWidth-1:0] id_fifo_q [MAX_OUTSTANDING];
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                unexpected_q;

    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] v);
        if (v == IdxWidth'(XBAR_NMASTER - 1)) return '0;
        else return v + IdxWidth'(1);
    endfunction

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        if (p == PtrWidth'(MAX_OUTSTANDING - 1)) return '0;
        else return p + PtrWidth'(1);
    endfunction

    // A locked master keeps the port even if it drops req; otherwise scan from rr.
    always_comb begin
        found    = 1'b0;
        sel      = rr_q;
        cand     = rr_q;
        eligible = 1'b0;
        for (int i = 0; i < int'(XBAR_NMASTER); i++) begin
            if (!found && master_req_i[cand].req) begin
                sel   = cand;
                found = 1'b1;
            end
            cand = next_idx(cand);
        end
        if (lock_q) begin
            sel      = lock_idx_q;
            eligible = master_req_i[lock_idx_q].req;
        end else begin
            eligible = found;
        end
    end

    // A full FIFO blocks new requests even when a response pops this cycle.
    assign fifo_full       = (count_q == CntWidth'(MAX_OUTSTANDING));
    assign slave_req_valid = eligible & ~fifo_full & ~rst_i;
    assign accept          = slave_req_valid & slave_resp_i.gnt;
    assign pop             = slave_resp_i.rvalid & (count_q != '0) & ~rst_i;
    assign head_idx        = id_fifo_q[rd_ptr_q];

    always_comb begin
        slave_req_o     = master_req_i[sel];
        slave_req_o.req = slave_req_valid;
        for (int m = 0; m < int'(XBAR_NMASTER); m++) begin
            master_resp_o[m]        = '0;
            master_resp_o[m].gnt    = accept && (sel == IdxWidth'(m));
            master_resp_o[m].rvalid = pop && (head_idx == IdxWidth'(m));
            master_resp_o[m].rdata  = slave_resp_i.rdata;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (accept) begin
            lock_q <= 1'b0;
            rr_q   <= next_idx(sel);
        end else if (slave_req_valid) begin
            lock_q     <= 1'b1;
            lock_idx_q <= sel;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_fifo_q[wr_ptr_q] <= sel;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)    rd_ptr_q <= next_ptr(rd_ptr_q);
            if (accept && !pop)      count_q <= count_q + CntWidth'(1);
            else if (!accept && pop) count_q <= count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) unexpected_q <= 1'b0;
        else       unexpected_q <= slave_resp_i.rvalid && (count_q == '0);
    end

    assign unexpected_rsp_o = unexpected_q;

endmodule
